// File: rtl/mux_scan_ctrl_pkg.sv
// Shared definitions for the analog mux scan controller: FSM encoding,
// command byte layout and the marker stored for a timed-out conversion.
package mux_scan_ctrl_pkg;

    // Scan sequencer states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_CONV   = 3'd3,
        ST_STORE  = 3'd4,
        ST_DONE   = 3'd5
    } scan_state_t;

    // Command byte layout: [7]=start, [6]=1.65k load, [5]=240R load, [3:0]=last channel
    localparam int CMD_START_BIT = 7;
    localparam int CMD_PR_BIT    = 6;
    localparam int CMD_PDR_BIT   = 5;
    localparam int CMD_LAST_MSB  = 3;

    // Value written to the buffer when a channel's conversion never completes
    localparam logic [15:0] TIMEOUT_MARK = 16'hFFFF;

    function automatic int max_int(input int x, input int y);
        return (x > y) ? x : y;
    endfunction

    // Requested last channel limited to the channels that actually exist
    function automatic logic [3:0] clamp_last(input logic [3:0] req, input int n_ch);
        if (int'(req) >= n_ch) begin
            return 4'(n_ch - 1);
        end
        return req;
    endfunction

endpackage

// File: rtl/mux_scan_ctrl_result_buf.sv
// Byte buffer for scan results: two bytes written per store (high byte at the
// lower address), one byte popped per read, show-ahead output, full clear.
module scan_result_buf #(
    parameter int DEPTH = 32,
    parameter int LEN_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             clr_i,
    input  logic             wr_i,
    input  logic [15:0]      wr_data_i,
    input  logic             pop_i,
    output logic [7:0]       rd_data_o,
    output logic [LEN_W-1:0] len_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [7:0]       mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [PTR_W-1:0] wr_ptr_nx;
    logic             pop_ok;

    assign wr_ptr_nx = wr_ptr_q + PTR_W'(1);
    assign pop_ok    = pop_i && (len_q != '0);

    // Next pointer/length values; clear wins over write and pop
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        len_d    = len_q;
        if (clr_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            len_d    = '0;
        end else begin
            if (wr_i) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(2);
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            len_d = len_q + (wr_i ? LEN_W'(2) : LEN_W'(0)) - (pop_ok ? LEN_W'(1) : LEN_W'(0));
        end
    end

    // Pointer and length registers
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            len_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            len_q    <= len_d;
        end
    end

    // Storage needs no reset: nothing is visible until len is non-zero
    always_ff @(posedge clk) begin
        if (wr_i && !clr_i) begin
            mem_q[wr_ptr_q]  <= wr_data_i[15:8];
            mem_q[wr_ptr_nx] <= wr_data_i[7:0];
        end
    end

    assign rd_data_o = (len_q == '0) ? 8'h00 : mem_q[rd_ptr_q];
    assign len_o     = len_q;

endmodule

// File: rtl/mux_scan_ctrl.sv
// Analog output mux scan sequencer: steps the mux address over channels
// 0..last with a fixed load applied, settles, triggers one ADC conversion per
// channel and queues the 16-bit results as bytes on the have_msg/rdreq bus.
// Bus handshake: a byte is consumed on a clock edge where rdreq and have_msg
// are both high; slave_data always shows the oldest unread byte.
module mux_scan_ctrl
    import mux_scan_ctrl_pkg::*;
#(
    parameter int N_CH        = 16,
    parameter int SETTLE_CYC  = 1000,
    parameter int ADC_W       = 12,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic [7:0]       master_data,
    input  logic             valid,
    input  logic             rdreq,
    output logic             have_msg,
    output logic [7:0]       slave_data,
    output logic [7:0]       len,
    output logic [3:0]       a,
    output logic             load_pr_3v7,
    output logic             load_pdr,
    output logic             adc_start,
    input  logic             adc_done,
    input  logic [ADC_W-1:0] adc_data,
    output logic             busy,
    output logic             err,
    output logic [2:0]       state_dbg
);

    localparam int DEPTH = 2 * N_CH;
    localparam int LEN_W = $clog2(DEPTH + 1);
    localparam int CNT_W = $clog2(max_int(max_int(SETTLE_CYC, TIMEOUT_CYC), 2));
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] TMO_LAST    = CNT_W'(TIMEOUT_CYC - 1);

    scan_state_t      state_q, state_d;
    logic [3:0]       ch_q, ch_d;
    logic [3:0]       last_q, last_d;
    logic             pr_q, pr_d;
    logic             pdr_q, pdr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]      val_q, val_d;
    logic             err_q, err_d;
    logic             adc_start_q;
    logic             buf_clr;
    logic             buf_wr;
    logic             buf_pop;
    logic [LEN_W-1:0] buf_len;
    logic             start_cmd;
    logic             cmd_unused;

    // Bit 4 of the command byte carries no meaning
    assign cmd_unused = master_data[4];
    assign start_cmd  = valid && master_data[CMD_START_BIT];

    // Next-state logic; one counter serves both the settle and timeout waits
    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        last_d  = last_q;
        pr_d    = pr_q;
        pdr_d   = pdr_q;
        cnt_d   = cnt_q;
        val_d   = val_q;
        err_d   = err_q;
        buf_clr = 1'b0;
        buf_wr  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start_cmd) begin
                    last_d  = clamp_last(master_data[CMD_LAST_MSB:0], N_CH);
                    pr_d    = master_data[CMD_PR_BIT];
                    pdr_d   = master_data[CMD_PDR_BIT];
                    ch_d    = '0;
                    err_d   = 1'b0;
                    buf_clr = 1'b1;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                cnt_d   = '0;
                state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_CONV;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_CONV: begin
                // A conversion finishing on the timeout cycle still counts
                if (adc_done) begin
                    val_d   = 16'(adc_data);
                    state_d = ST_STORE;
                end else if (cnt_q == TMO_LAST) begin
                    val_d   = TIMEOUT_MARK;
                    err_d   = 1'b1;
                    state_d = ST_STORE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_STORE: begin
                buf_wr = 1'b1;
                if (ch_q == last_q) begin
                    state_d = ST_DONE;
                end else begin
                    ch_d    = ch_q + 4'd1;
                    state_d = ST_SETUP;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sequencer state and scan context registers
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= ST_IDLE;
            ch_q    <= '0;
            last_q  <= '0;
            pr_q    <= 1'b0;
            pdr_q   <= 1'b0;
            cnt_q   <= '0;
            val_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            last_q  <= last_d;
            pr_q    <= pr_d;
            pdr_q   <= pdr_d;
            cnt_q   <= cnt_d;
            val_q   <= val_d;
            err_q   <= err_d;
        end
    end

    // Conversion trigger is registered so it is high for exactly the first CONV cycle
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            adc_start_q <= 1'b0;
        end else begin
            adc_start_q <= (state_q == ST_SETTLE) && (state_d == ST_CONV);
        end
    end

    assign busy        = (state_q == ST_SETUP) || (state_q == ST_SETTLE) ||
                         (state_q == ST_CONV)  || (state_q == ST_STORE);
    assign a           = busy ? ch_q : 4'd0;
    assign load_pr_3v7 = busy && pr_q;
    assign load_pdr    = busy && pdr_q;
    assign adc_start   = adc_start_q;
    assign err         = err_q;
    assign state_dbg   = state_q;

    assign have_msg = (buf_len != '0) && !busy;
    assign buf_pop  = rdreq && have_msg;
    assign len      = 8'(buf_len);

    scan_result_buf #(
        .DEPTH (DEPTH),
        .LEN_W (LEN_W)
    ) u_buf (
        .clk       (clk),
        .n_rst     (n_rst),
        .clr_i     (buf_clr),
        .wr_i      (buf_wr),
        .wr_data_i (val_q),
        .pop_i     (buf_pop),
        .rd_data_o (slave_data),
        .len_o     (buf_len)
    );

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed bench for mux_scan_ctrl with a small channel count, short settle
// and short timeout so every scan path is reachable in a few hundred cycles.
module tb_mux_scan_ctrl;
    import mux_scan_ctrl_pkg::*;

    localparam int N_CH        = 4;
    localparam int SETTLE_CYC  = 4;
    localparam int ADC_W       = 12;
    localparam int TIMEOUT_CYC = 8;

    logic             clk = 1'b0;
    logic             n_rst = 1'b0;
    logic [7:0]       master_data = 8'h00;
    logic             valid = 1'b0;
    logic             rdreq = 1'b0;
    logic             have_msg;
    logic [7:0]       slave_data;
    logic [7:0]       len;
    logic [3:0]       a;
    logic             load_pr_3v7;
    logic             load_pdr;
    logic             adc_start;
    logic             adc_done = 1'b0;
    logic [ADC_W-1:0] adc_data = '0;
    logic             busy;
    logic             err;
    logic [2:0]       state_dbg;

    int n_chk  = 0;
    int n_fail = 0;

    mux_scan_ctrl #(
        .N_CH        (N_CH),
        .SETTLE_CYC  (SETTLE_CYC),
        .ADC_W       (ADC_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .master_data (master_data),
        .valid       (valid),
        .rdreq       (rdreq),
        .have_msg    (have_msg),
        .slave_data  (slave_data),
        .len         (len),
        .a           (a),
        .load_pr_3v7 (load_pr_3v7),
        .load_pdr    (load_pdr),
        .adc_start   (adc_start),
        .adc_done    (adc_done),
        .adc_data    (adc_data),
        .busy        (busy),
        .err         (err),
        .state_dbg   (state_dbg)
    );

    // clock
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [7:0] cmd);
        master_data = cmd;
        valid       = 1'b1;
        tick();
        valid       = 1'b0;
        master_data = 8'h00;
    endtask

    task automatic read_byte(input string tag, input logic [7:0] exp);
        chk(tag, 32'(slave_data), 32'(exp));
        rdreq = 1'b1;
        tick();
        rdreq = 1'b0;
    endtask

    // Called in the SETUP cycle; returns in the first CONV cycle (adc_start high)
    task automatic wait_conv(input bit inject, output int lat);
        lat = 0;
        while (adc_start !== 1'b1 && lat < 50) begin
            adc_done = inject && (lat == 1);
            adc_data = (inject && lat == 1) ? 12'hABC : 12'h000;
            tick();
            lat++;
        end
        adc_done = 1'b0;
        adc_data = '0;
        chk("settle_latency", 32'(lat), 32'd5);
    endtask

    // One channel from SETUP to the cycle after STORE; ADC answers 3 cycles after trigger
    task automatic run_channel(input logic [11:0] data, input int exp_a, input bit exp_pr,
                               input bit exp_pdr, input bit inject, input bit send_extra,
                               input logic [7:0] extra);
        int lat;
        wait_conv(inject, lat);
        chk("mux_addr", 32'(a), 32'(exp_a));
        chk("load_pr_3v7", 32'(load_pr_3v7), 32'(exp_pr));
        chk("load_pdr", 32'(load_pdr), 32'(exp_pdr));
        chk("busy_in_conv", 32'(busy), 32'd1);
        chk("have_msg_busy", 32'(have_msg), 32'd0);
        if (send_extra) send_cmd(extra);
        else tick();
        chk("adc_start_one_cycle", 32'(adc_start), 32'd0);
        tick();
        tick();
        adc_done = 1'b1;
        adc_data = data;
        tick();
        adc_done = 1'b0;
        adc_data = '0;
        chk("state_store", 32'(state_dbg), 32'(ST_STORE));
        tick();
    endtask

    initial begin
        // reset
        n_rst = 1'b0;
        tick();
        tick();
        chk("rst_a", 32'(a), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_len", 32'(len), 32'd0);
        chk("rst_have_msg", 32'(have_msg), 32'd0);
        chk("rst_slave_data", 32'(slave_data), 32'd0);
        chk("rst_adc_start", 32'(adc_start), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        n_rst = 1'b1;
        tick();

        // bit7 clear: ignored
        send_cmd(8'h42);
        chk("no_start_idle", 32'(state_dbg), 32'(ST_IDLE));

        // main scan: start, 1.65k load, last=2
        send_cmd(8'hC2);
        chk("setup_state", 32'(state_dbg), 32'(ST_SETUP));
        run_channel(12'h123, 0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        chk("len_after_ch0", 32'(len), 32'd2);
        rdreq = 1'b1;
        run_channel(12'h456, 1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        rdreq = 1'b0;
        chk("no_pop_while_busy", 32'(len), 32'd4);
        run_channel(12'h789, 2, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
        chk("done_busy", 32'(busy), 32'd0);
        chk("done_a", 32'(a), 32'd0);
        chk("done_pr", 32'(load_pr_3v7), 32'd0);
        chk("done_pdr", 32'(load_pdr), 32'd0);
        chk("done_len", 32'(len), 32'd6);
        chk("done_have_msg", 32'(have_msg), 32'd1);
        chk("done_err", 32'(err), 32'd0);
        tick();
        read_byte("rd0", 8'h01);
        read_byte("rd1", 8'h23);
        read_byte("rd2", 8'h04);
        read_byte("rd3", 8'h56);
        read_byte("rd4", 8'h07);
        read_byte("rd5", 8'h89);
        chk("empty_have_msg", 32'(have_msg), 32'd0);
        chk("empty_len", 32'(len), 32'd0);
        chk("empty_slave_data", 32'(slave_data), 32'd0);
        rdreq = 1'b1;
        tick();
        rdreq = 1'b0;
        chk("rdreq_empty_len", 32'(len), 32'd0);

        // timeout: 240R load, last=0, ADC never answers
        send_cmd(8'hA0);
        begin
            int lat;
            wait_conv(1'b0, lat);
        end
        chk("tmo_pr", 32'(load_pr_3v7), 32'd0);
        chk("tmo_pdr", 32'(load_pdr), 32'd1);
        repeat (7) tick();
        chk("tmo_still_conv", 32'(state_dbg), 32'(ST_CONV));
        tick();
        chk("tmo_store", 32'(state_dbg), 32'(ST_STORE));
        chk("tmo_err", 32'(err), 32'd1);
        tick();
        chk("tmo_len", 32'(len), 32'd2);
        tick();
        read_byte("tmo_hi", 8'hFF);
        read_byte("tmo_lo", 8'hFF);
        chk("tmo_err_sticky", 32'(err), 32'd1);

        // start ignored while busy
        send_cmd(8'h81);
        chk("err_cleared", 32'(err), 32'd0);
        run_channel(12'hA5A, 0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h8F);
        run_channel(12'h3C3, 1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        chk("ign_done", 32'(state_dbg), 32'(ST_DONE));
        chk("ign_len", 32'(len), 32'd4);
        tick();
        read_byte("ign0", 8'h0A);
        read_byte("ign1", 8'h5A);
        read_byte("ign2", 8'h03);
        read_byte("ign3", 8'hC3);
        chk("ign_len_end", 32'(len), 32'd0);

        // reset during SETTLE of channel 1
        send_cmd(8'hE1);
        run_channel(12'h111, 0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        tick();
        tick();
        chk("pre_rst_settle", 32'(state_dbg), 32'(ST_SETTLE));
        n_rst = 1'b0;
        #2;
        chk("mid_rst_a", 32'(a), 32'd0);
        chk("mid_rst_pr", 32'(load_pr_3v7), 32'd0);
        chk("mid_rst_pdr", 32'(load_pdr), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_len", 32'(len), 32'd0);
        chk("mid_rst_have_msg", 32'(have_msg), 32'd0);
        chk("mid_rst_slave_data", 32'(slave_data), 32'd0);
        #2;
        n_rst = 1'b1;
        tick();
        chk("post_rst_idle", 32'(state_dbg), 32'(ST_IDLE));
        send_cmd(8'h80);
        run_channel(12'hBEE, 0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        chk("post_rst_len", 32'(len), 32'd2);
        tick();
        chk("post_rst_show_ahead", 32'(slave_data), 32'h0B);

        // clamp to last channel 3 and discard the 2 unread bytes
        send_cmd(8'h8F);
        chk("discard_len", 32'(len), 32'd0);
        for (int i = 0; i < N_CH; i++) begin
            run_channel(12'(32'h111 * (i + 1)), i, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        end
        chk("clamp_done", 32'(state_dbg), 32'(ST_DONE));
        chk("clamp_len", 32'(len), 32'd8);
        tick();
        read_byte("cl0", 8'h01);
        read_byte("cl1", 8'h11);
        read_byte("cl2", 8'h02);
        read_byte("cl3", 8'h22);
        read_byte("cl4", 8'h03);
        read_byte("cl5", 8'h33);
        read_byte("cl6", 8'h04);
        read_byte("cl7", 8'h44);
        chk("clamp_empty", 32'(have_msg), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mux_scan_ctrl.md
Name: mux_scan_ctrl

Overview:
Sequences the analog output multiplexer for automated measurement of all Q[i] outputs.
- On a start command it steps the mux address over channels 0..last and applies the selected load (1.65 kOhm / 240 Ohm) for the whole scan.
- Per channel it waits a settle time, triggers one ADC conversion and stores the result.
- Results are returned as a byte stream on the standard have_msg/rdreq/slave_data/len bus slot.

Parameters:
N_CH, 16, number of mux channels (max 16, address width 4)
SETTLE_CYC, 1000, clk cycles between address/load change and ADC trigger (>=1)
ADC_W, 12, ADC result width (<=16), zero-extended to 16 bits in buffer
TIMEOUT_CYC, 65535, max clk cycles to wait for adc_done per channel

Ports:
clk  in  1  system clock
n_rst  in  1  asynchronous active-low reset
master_data  in  8  command byte
valid  in  1  command strobe, 1 cycle per byte
rdreq  in  1  read request, pops one result byte
have_msg  out  1  result bytes available
slave_data  out  8  current result byte (show-ahead)
len  out  8  number of unread result bytes
a  out  4  mux address
load_pr_3v7  out  1  1.65 kOhm load enable
load_pdr  out  1  240 Ohm load enable
adc_start  out  1  one-cycle conversion trigger
adc_done  in  1  conversion complete, adc_data valid same cycle
adc_data  in  ADC_W  conversion result
busy  out  1  scan in progress
err  out  1  sticky: at least one channel timed out in last scan

Behaviour:
- Reset: a=0, load_pr_3v7=0, load_pdr=0, adc_start=0, busy=0, err=0, have_msg=0, len=0, slave_data=0. FSM goes to IDLE and the buffer is emptied. Reset mid-scan aborts the scan immediately.
- Command format: bit7=start, bit6=load_pr_3v7, bit5=load_pdr, bits3:0=last channel.
  - last >= N_CH is clamped to N_CH-1.
  - valid with bit7=0 is ignored.
  - A start while busy is ignored.
- FSM states and transitions:
  - IDLE: valid&bit7 -> SETUP. Latch last and the load bits. Clear the buffer (discards unread bytes) and clear err. ch=0.
  - SETUP (1 cycle): drive a=ch and the loads; busy=1; reset the settle counter -> SETTLE.
  - SETTLE: count SETTLE_CYC cycles -> CONV. adc_start=1 for exactly the first CONV cycle.
  - CONV: wait for adc_done.
    - adc_done: capture adc_data -> STORE.
    - Timeout counter reaches TIMEOUT_CYC first: capture 16'hFFFF, set err -> STORE.
    - adc_done in the same cycle as timeout: adc_done wins.
  - STORE (1 cycle): write the high byte then the low byte of the 16-bit value to the buffer; len+=2.
    - ch==last -> DONE.
    - Otherwise ch+=1 -> SETUP.
  - DONE (1 cycle): a=0, loads=0, busy=0 -> IDLE.
- Latency: the first adc_start occurs SETTLE_CYC+1 cycles after the cycle following the accepted command.
- Result buffer: 2*N_CH bytes, channel ascending, high byte first.
  - have_msg = (len!=0) & !busy.
  - slave_data = buf[rd_ptr] combinationally; 0 when len==0.
  - rdreq with have_msg: rd_ptr+1, len-1 next cycle.
  - rdreq with len==0 or while busy: ignored.
- adc_done outside CONV is ignored. adc_data is sampled only on adc_done in CONV.
- Counters are sized from the parameters. No wrap-around is possible since len <= 2*N_CH <= 32.

Decomposition:
- Shared package: FSM state encoding, command bit positions, timeout marker 16'hFFFF.
- One natural sub-module, scan_result_buf: a byte buffer with write pointer, read pointer and len. It takes a 2-byte write port, pop and clear, and provides a show-ahead output.

Test Plan:
- SETTLE_CYC=4: cmd 8'hC2 (start, pr_3v7, last=2). adc_done returns 12'h123, 12'h456, 12'h789 three cycles after each adc_start.
  - Required: a steps 0,1,2; load_pr_3v7=1 and load_pdr=0 during the scan.
  - Required: len=6; reads 01,23,04,56,07,89; then have_msg=0, a=0, loads=0.
- Timeout: TIMEOUT_CYC=8, cmd 8'hA0 (start, pdr, last=0), adc_done never asserted -> err=1, bytes FF,FF, len=2.
- Start ignored: cmd 8'h81, then 8'h8F issued during busy -> exactly 4 bytes produced, a never exceeds 1.
- Reset mid-scan: assert n_rst low during SETTLE of ch1 -> all outputs at reset values, len=0; a following cmd 8'h80 runs normally.
- Clamp and discard: N_CH=4, cmd 8'h8F with results unread from a prior scan -> old bytes discarded, 8 new bytes, a max=3.
- Bus edge cases: rdreq with len=0 -> len stays 0. rdreq during busy -> no pop. adc_done during SETTLE -> ignored, value not stored.
